// File: rtl/ppcom_pipe_if.sv
// Stream bundle between the PP generator, the partial-product compressor and the output register.
interface ppcom_pipe_if #(
  parameter int N = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [N*N-1:0]   pp;
  logic             ap_en;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   res;
  logic             res_err;

  modport master (output in_valid, pp, ap_en, out_ready,
                  input  in_ready, out_valid, res, res_err);
  modport slave  (input  in_valid, pp, ap_en, out_ready,
                  output in_ready, out_valid, res, res_err);
endinterface

// File: rtl/ppcom_pipe.sv
// N x N partial-product compressor with per-beat exact/approximate mode; 3-stage pipeline (3 cycles).
// Backpressure ripples combinationally from out_ready to in_ready; no skid buffer.
module ppcom_pipe #(
  parameter int N       = 12,
  parameter int AP_COLS = 10,
  parameter int SIGNED  = 1
) (
  input  logic        clk,
  input  logic        rst,
  ppcom_pipe_if.slave io
);
  localparam int W = 2 * N;
  localparam int G = (N + 3) / 4;

  function automatic logic [W-1:0] low_mask();
    logic [W-1:0] m;
    m = '0;
    for (int c = 0; c < W; c++) if (c < AP_COLS) m[c] = 1'b1;
    return m;
  endfunction

  localparam logic [W-1:0] AP_MASK = low_mask();
  localparam logic [W-1:0] K_CORR  = (SIGNED != 0) ? ((W'(1) << N) | (W'(1) << (W - 1))) : '0;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] c;
  } cs_t;

  function automatic cs_t csa3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d);
    cs_t r;
    r.s = a ^ b ^ d;
    r.c = ((a & b) | (a & d) | (b & d)) << 1;
    return r;
  endfunction

  function automatic cs_t csa4(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] d, input logic [W-1:0] e);
    cs_t t;
    t = csa3(a, b, d);
    return csa3(t.s, t.c, e);
  endfunction

  logic         v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic         ap0_q, ap0_d, ap1_q, ap1_d;
  logic [W-1:0] or0_q, or0_d, or1_q, or1_d;
  cs_t          grp_x_q [G];
  cs_t          grp_x_d [G];
  cs_t          grp_m_q [G];
  cs_t          grp_m_d [G];
  cs_t          sum_x_q, sum_x_d, sum_m_q, sum_m_d;
  logic [W-1:0] res_q, res_d;
  logic         err_q, err_d;
  logic         en0, en1, en2;
  logic [W-1:0] rows [4*G];
  logic [W-1:0] exact_sum, approx_sum;

  assign en2 = ~v2_q | io.out_ready;
  assign en1 = ~v1_q | en2;
  assign en0 = ~v0_q | en1;

  assign io.in_ready  = en0;
  assign io.out_valid = v2_q;
  assign io.res       = res_q;
  assign io.res_err   = err_q;

  always_comb begin
    // Rows beyond N stay zero so the last 4-row group is padded.
    for (int r = 0; r < 4 * G; r++) begin
      rows[r] = '0;
      if (r < N) rows[r] = W'(io.pp[N*r +: N]) << r;
    end

    v0_d  = en0 ? io.in_valid : v0_q;
    ap0_d = ap0_q;
    or0_d = or0_q;
    for (int g = 0; g < G; g++) begin
      grp_x_d[g] = grp_x_q[g];
      grp_m_d[g] = grp_m_q[g];
    end
    if (io.in_valid && en0) begin
      ap0_d = io.ap_en;
      or0_d = '0;
      for (int r = 0; r < N; r++) or0_d = or0_d | rows[r];
      or0_d = or0_d & AP_MASK;
      for (int g = 0; g < G; g++) begin
        grp_x_d[g] = csa4(rows[4*g], rows[4*g+1], rows[4*g+2], rows[4*g+3]);
        // Masking before compression keeps low-column carries out of the approximate sum.
        grp_m_d[g] = csa4(rows[4*g] & ~AP_MASK, rows[4*g+1] & ~AP_MASK,
                          rows[4*g+2] & ~AP_MASK, rows[4*g+3] & ~AP_MASK);
      end
    end

    v1_d    = en1 ? v0_q : v1_q;
    ap1_d   = ap1_q;
    or1_d   = or1_q;
    sum_x_d = sum_x_q;
    sum_m_d = sum_m_q;
    if (en1 && v0_q) begin
      ap1_d   = ap0_q;
      or1_d   = or0_q;
      sum_x_d = '0;
      sum_m_d = '0;
      for (int g = 0; g < G; g++) begin
        sum_x_d = csa4(sum_x_d.s, sum_x_d.c, grp_x_q[g].s, grp_x_q[g].c);
        sum_m_d = csa4(sum_m_d.s, sum_m_d.c, grp_m_q[g].s, grp_m_q[g].c);
      end
    end

    exact_sum  = sum_x_q.s + sum_x_q.c + K_CORR;
    approx_sum = sum_m_q.s + sum_m_q.c + K_CORR + or1_q;
    v2_d  = en2 ? v1_q : v2_q;
    res_d = res_q;
    err_d = err_q;
    if (en2 && v1_q) begin
      res_d = ap1_q ? approx_sum : exact_sum;
      err_d = ap1_q && (approx_sum != exact_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      ap0_q   <= 1'b0;
      ap1_q   <= 1'b0;
      or0_q   <= '0;
      or1_q   <= '0;
      for (int g = 0; g < G; g++) begin
        grp_x_q[g] <= '0;
        grp_m_q[g] <= '0;
      end
      sum_x_q <= '0;
      sum_m_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      ap0_q   <= ap0_d;
      ap1_q   <= ap1_d;
      or0_q   <= or0_d;
      or1_q   <= or1_d;
      for (int g = 0; g < G; g++) begin
        grp_x_q[g] <= grp_x_d[g];
        grp_m_q[g] <= grp_m_d[g];
      end
      sum_x_q <= sum_x_d;
      sum_m_q <= sum_m_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ppcom_pipe.sv
`timescale 1ns/1ps
// Three compressors (signed, unsigned, approximation disabled) driven in lockstep and
// compared against a column-arithmetic model of the product.
module tb_ppcom_pipe;
  localparam int N  = 12;
  localparam int W  = 2 * N;
  localparam int ND = 3;
  localparam int SIG [ND] = '{1, 0, 1};
  localparam int APC [ND] = '{10, 10, 0};

  typedef struct packed {
    logic [N*N-1:0] p;
    logic           a;
  } beat_t;

  typedef struct {
    logic [N*N-1:0] p;
    logic           a;
    int             d;
    logic [W:0]     want;
  } dir_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, ap_en, out_ready;
  logic [N*N-1:0] pp;
  logic [W-1:0]   res_o [ND];
  logic           err_o [ND];
  logic           ov_o  [ND];
  logic           ir_o  [ND];

  int         checks   = 0;
  int         failures = 0;
  beat_t      sb [ND][$];
  logic [W:0] last_out [ND];
  int         last_lat [ND];

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    ppcom_pipe_if #(.N(N)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.pp        = pp;
    assign bus.ap_en     = ap_en;
    assign bus.out_ready = out_ready;
    ppcom_pipe #(.N(N), .AP_COLS(APC[d]), .SIGNED(SIG[d])) u_dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
    );
    assign res_o[d] = bus.res;
    assign err_o[d] = bus.res_err;
    assign ov_o[d]  = bus.out_valid;
    assign ir_o[d]  = bus.in_ready;
  end

  // Returns {res_err, res} from the weighted bit sum and the per-column OR rule.
  function automatic logic [W:0] model(input logic [N*N-1:0] p, input logic a, input int d);
    longint exact_v = 0;
    longint hi_v    = 0;
    longint orv     = 0;
    longint k;
    logic [W-1:0] ex, apx, r;
    k = (SIG[d] != 0) ? ((longint'(1) << N) + (longint'(1) << (W - 1))) : 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (p[N*i+j]) begin
          exact_v += longint'(1) << (i + j);
          if (i + j >= APC[d]) hi_v += longint'(1) << (i + j);
          else orv = orv | (longint'(1) << (i + j));
        end
    ex  = W'(exact_v + k);
    apx = W'(hi_v + k + orv);
    r   = a ? apx : ex;
    return {a && (r != ex), r};
  endfunction

  function automatic logic [N*N-1:0] rand_pp();
    logic [159:0] t;
    for (int k = 0; k < 5; k++) t[32*k +: 32] = $urandom;
    if ($urandom_range(0, 3) == 0)
      for (int k = 0; k < 5; k++) t[32*k +: 32] = t[32*k +: 32] & $urandom;
    return t[N*N-1:0];
  endfunction

  task automatic run_beat(input logic [N*N-1:0] p, input logic a);
    in_valid = 1'b1; pp = p; ap_en = a; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; pp = 'x; ap_en = 1'bx;
    for (int d = 0; d < ND; d++) begin last_lat[d] = -1; last_out[d] = '0; end
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        if (ov_o[d] === 1'b1 && last_lat[d] < 0) begin
          last_lat[d] = t;
          last_out[d] = {err_o[d], res_o[d]};
        end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; #1 rst = 1'b1; #2;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov_o[d] !== 1'b0 || res_o[d] !== '0 || err_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: valid=%b res=%h err=%b, want 0/0/0", d, ov_o[d], res_o[d], err_o[d]);
      end
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ir_o[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready dut%0d: got %b want 1", d, ir_o[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [N*N-1:0] ones, one0, two;
    dir_t tab [6];
    ones = '1; one0 = '0; one0[0] = 1'b1; two = '0; two[1] = 1'b1; two[N] = 1'b1;
    tab[0] = '{ones, 1'b0, 1, {1'b0, 24'hFFE001}};
    tab[1] = '{ones, 1'b1, 1, {1'b1, 24'hFFBFFF}};
    tab[2] = '{'0,   1'b1, 0, {1'b0, 24'h801000}};
    tab[3] = '{one0, 1'b1, 0, {1'b0, 24'h801001}};
    tab[4] = '{two,  1'b0, 1, {1'b0, 24'h000004}};
    tab[5] = '{two,  1'b1, 1, {1'b1, 24'h000002}};
    foreach (tab[e]) begin
      run_beat(tab[e].p, tab[e].a);
      checks++;
      if (last_out[tab[e].d] !== tab[e].want) begin
        failures++;
        $display("FAIL directed_%0d dut%0d: got err,res=%h want %h", e, tab[e].d, last_out[tab[e].d], tab[e].want);
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (last_lat[d] !== 3 || last_out[d] !== model(tab[e].p, tab[e].a, d)) begin
          failures++;
          $display("FAIL directed_model_%0d dut%0d: lat=%0d out=%h want lat=3 out=%h",
                   e, d, last_lat[d], last_out[d], model(tab[e].p, tab[e].a, d));
        end
      end
    end
  endtask

  task automatic test_stream();
    beat_t beats [8];
    int nout [ND];
    logic want_v;
    for (int k = 0; k < 8; k++) begin beats[k].p = rand_pp(); beats[k].a = 1'($urandom_range(0, 1)); end
    for (int d = 0; d < ND; d++) nout[d] = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin in_valid = 1'b1; pp = beats[c].p; ap_en = beats[c].a; end
      else begin in_valid = 1'b0; pp = 'x; ap_en = 1'bx; end
      want_v = (c >= 3 && c <= 10);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (ov_o[d] !== want_v || (c < 8 && ir_o[d] !== 1'b1)) begin
          failures++;
          $display("FAIL stream_timing dut%0d cycle%0d: valid=%b ready=%b want valid=%b ready=1", d, c, ov_o[d], ir_o[d], want_v);
        end
        if (ov_o[d] === 1'b1 && nout[d] < 8) begin
          checks++;
          if ({err_o[d], res_o[d]} !== model(beats[nout[d]].p, beats[nout[d]].a, d)) begin
            failures++;
            $display("FAIL stream_res dut%0d beat%0d: got %h want %h", d, nout[d], {err_o[d], res_o[d]},
                     model(beats[nout[d]].p, beats[nout[d]].a, d));
          end
          nout[d]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (nout[d] != 8) begin failures++; $display("FAIL stream_count dut%0d: got %0d want 8", d, nout[d]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t beats [6];
    int sent = 0;
    int nout [ND];
    logic want_r;
    beat_t b;
    for (int k = 0; k < 6; k++) begin beats[k].p = rand_pp(); beats[k].a = 1'($urandom_range(0, 1)); end
    for (int d = 0; d < ND; d++) begin nout[d] = 0; sb[d].delete(); end
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      if (sent < 6) begin in_valid = 1'b1; pp = beats[sent].p; ap_en = beats[sent].a; end
      else begin in_valid = 1'b0; pp = 'x; ap_en = 1'bx; end
      @(negedge clk);
      want_r = (c < 3 || c == 5);
      for (int d = 0; d < ND; d++) begin
        if (c <= 5) begin
          checks++;
          if (ir_o[d] !== want_r) begin
            failures++;
            $display("FAIL bp_in_ready dut%0d cycle%0d: got %b want %b", d, c, ir_o[d], want_r);
          end
        end
        if (c == 3 || c == 4) begin
          checks++;
          if (ov_o[d] !== 1'b1 || {err_o[d], res_o[d]} !== model(beats[0].p, beats[0].a, d)) begin
            failures++;
            $display("FAIL bp_hold dut%0d cycle%0d: valid=%b out=%h want 1/%h", d, c, ov_o[d],
                     {err_o[d], res_o[d]}, model(beats[0].p, beats[0].a, d));
          end
        end
        if (in_valid && ir_o[d]) sb[d].push_back(beats[sent]);
        if (ov_o[d] && out_ready) begin
          checks++;
          if (sb[d].size() == 0) begin
            failures++;
            $display("FAIL bp_spurious dut%0d cycle%0d: got %h want no output", d, c, {err_o[d], res_o[d]});
          end else begin
            b = sb[d].pop_front();
            if ({err_o[d], res_o[d]} !== model(b.p, b.a, d)) begin
              failures++;
              $display("FAIL bp_res dut%0d out%0d: got %h want %h", d, nout[d], {err_o[d], res_o[d]}, model(b.p, b.a, d));
            end
          end
          nout[d]++;
        end
      end
      if (in_valid && ir_o[0]) sent++;
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (nout[d] != 6 || sb[d].size() != 0) begin
        failures++;
        $display("FAIL bp_drain dut%0d: outputs=%0d left=%0d want 6/0", d, nout[d], sb[d].size());
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [N*N-1:0] p;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; pp = rand_pp(); ap_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; pp = 'x; ap_en = 1'bx;
    rst = 1'b1; #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov_o[d] !== 1'b0 || res_o[d] !== '0 || err_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL midrst_clear dut%0d: valid=%b res=%h err=%b want 0/0/0", d, ov_o[d], res_o[d], err_o[d]);
      end
    end
    @(posedge clk); #1 rst = 1'b0; #1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (ov_o[d] !== 1'b0 || ir_o[d] !== 1'b1) begin
          failures++;
          $display("FAIL midrst_stale dut%0d cycle%0d: valid=%b ready=%b want 0/1", d, t, ov_o[d], ir_o[d]);
        end
      end
    end
    @(posedge clk); #1;
    p = rand_pp();
    run_beat(p, 1'b1);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (last_lat[d] !== 3 || last_out[d] !== model(p, 1'b1, d)) begin
        failures++;
        $display("FAIL midrst_next dut%0d: lat=%0d out=%h want lat=3 out=%h", d, last_lat[d], last_out[d], model(p, 1'b1, d));
      end
    end
  endtask

  task automatic test_random();
    logic  pend = 1'b0;
    int    nout = 0;
    beat_t cur, b;
    for (int d = 0; d < ND; d++) sb[d].delete();
    for (int c = 0; c < 320; c++) begin
      if (!pend) begin
        in_valid = (c < 280) && ($urandom_range(0, 3) != 0);
        if (in_valid) begin cur.p = rand_pp(); cur.a = 1'($urandom_range(0, 1)); pp = cur.p; ap_en = cur.a; end
        else begin pp = 'x; ap_en = 1'bx; end
      end
      out_ready = (c >= 280) || ($urandom_range(0, 9) < 6);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (in_valid && ir_o[d]) sb[d].push_back(cur);
        if (ov_o[d] && out_ready) begin
          checks++;
          if (sb[d].size() == 0) begin
            failures++;
            $display("FAIL rand_spurious dut%0d cycle%0d: got %h want no output", d, c, {err_o[d], res_o[d]});
          end else begin
            b = sb[d].pop_front();
            if ({err_o[d], res_o[d]} !== model(b.p, b.a, d)) begin
              failures++;
              $display("FAIL rand_res dut%0d cycle%0d: got %h want %h", d, c, {err_o[d], res_o[d]}, model(b.p, b.a, d));
            end
          end
          if (d == 0) nout++;
        end
      end
      pend = in_valid && !ir_o[0];
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (sb[d].size() != 0 || nout < 50) begin
        failures++;
        $display("FAIL rand_drain dut%0d: left=%0d outputs=%0d want 0 left and >=50 outputs", d, sb[d].size(), nout);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; pp = '0; ap_en = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
